issue_queue_gen: RTL and testbench

ISSUE_QUEUE_GEN -- requirements
Module: issue_queue_gen

---
 rtl/issue_queue_gen.sv | 157 +++++++++++++++
 tb/tb_issue_queue_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_gen.sv
// Age-ordered collapsing issue queue.
// Entries sit oldest-first from index 0. Each cycle this block:
//   - issues up to N_OUT of the oldest ready entries,
//   - drops branch-killed entries,
//   - applies register wakeups,
//   - appends new dispatch slots behind the surviving entries.
module issue_queue_gen #(
  parameter int unsigned WIDTH_REG = 3,
  parameter int unsigned WIDTH_TAG = 3,
  parameter int unsigned WIDTH_BRM = 3,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned N_IN      = 4,
  parameter int unsigned N_OUT     = 2,
  parameter int unsigned N_WAKE    = 4,
  localparam int unsigned WIDTH    = 7 + WIDTH_BRM + WIDTH_TAG + 3 * WIDTH_REG + 3,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_IN*WIDTH-1:0]       i_inst,
  input  logic [N_IN-1:0]             i_valid,
  input  logic                        i_en,
  input  logic [N_WAKE*WIDTH_REG-1:0] i_wdest,
  input  logic [N_WAKE-1:0]           i_wvalid,
  input  logic [WIDTH_BRM-1:0]        i_BrKill,
  output logic [N_OUT*WIDTH-1:0]      o_inst,
  output logic [N_OUT-1:0]            o_valid,
  output logic [CW-1:0]               o_free,
  output logic                        o_ready
);

  // Field offsets inside an entry: {uop, brm, tag, prd, pr2, pr1, val, p2, p1}
  localparam int unsigned P1_BIT  = 0;
  localparam int unsigned P2_BIT  = 1;
  localparam int unsigned VAL_BIT = 2;
  localparam int unsigned PR1_LSB = 3;
  localparam int unsigned PR2_LSB = 3 + WIDTH_REG;
  localparam int unsigned BRM_LSB = 3 + 3 * WIDTH_REG + WIDTH_TAG;

  logic [WIDTH-1:0] ent_q [DEPTH];
  logic [WIDTH-1:0] ent_d [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  logic [DEPTH-1:0] occ;
  logic [DEPTH-1:0] killed;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] issue;
  logic             accept;

  // Set p1/p2 for any source register that matches a valid wakeup port.
  function automatic logic [WIDTH-1:0] wake(input logic [WIDTH-1:0]        e,
                                            input logic [N_WAKE*WIDTH_REG-1:0] wdest,
                                            input logic [N_WAKE-1:0]       wvalid);
    logic [WIDTH-1:0] r;
    r = e;
    for (int w = 0; w < N_WAKE; w++) begin
      if (wvalid[w]) begin
        if (e[PR1_LSB +: WIDTH_REG] == wdest[w*WIDTH_REG +: WIDTH_REG]) r[P1_BIT] = 1'b1;
        if (e[PR2_LSB +: WIDTH_REG] == wdest[w*WIDTH_REG +: WIDTH_REG]) r[P2_BIT] = 1'b1;
      end
    end
    return r;
  endfunction

  assign o_free  = CW'(DEPTH) - cnt_q;
  assign o_ready = (o_free >= CW'(N_IN));

  // Classify stored entries: occupied, killed by the branch mask, ready to issue.
  always_comb begin
    occ    = '0;
    killed = '0;
    ready  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ[i]    = (CW'(i) < cnt_q);
      killed[i] = |(ent_q[i][BRM_LSB +: WIDTH_BRM] & i_BrKill);
      ready[i]  = occ[i] && ent_q[i][VAL_BIT] && ent_q[i][P1_BIT] && ent_q[i][P2_BIT] &&
                  !killed[i];
    end
  end

  // Pick the oldest ready entries; oldest lands on port 0.
  always_comb begin
    int n;
    n       = 0;
    issue   = '0;
    o_inst  = '0;
    o_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && n < N_OUT) begin
        issue[i] = 1'b1;
        for (int j = 0; j < N_OUT; j++) begin
          if (j == n) begin
            o_valid[j]                 = 1'b1;
            o_inst[j*WIDTH +: WIDTH]   = ent_q[i];
          end
        end
        n++;
      end
    end
  end

  // All-or-nothing dispatch acceptance against pre-removal free space.
  always_comb begin
    int pc;
    pc = 0;
    for (int s = 0; s < N_IN; s++) begin
      if (i_valid[s]) pc++;
    end
    accept = i_en && (pc <= int'(o_free));
  end

  // Compact survivors, apply wakeup, then append accepted dispatch slots.
  always_comb begin
    int               k;
    logic [WIDTH-1:0] e;
    k = 0;
    e = '0;
    for (int p = 0; p < DEPTH; p++) ent_d[p] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && !issue[i] && !killed[i]) begin
        e = wake(ent_q[i], i_wdest, i_wvalid);
        for (int p = 0; p < DEPTH; p++) begin
          if (p == k) ent_d[p] = e;
        end
        k++;
      end
    end
    if (accept) begin
      for (int s = 0; s < N_IN; s++) begin
        e = i_inst[s*WIDTH +: WIDTH];
        // A killed slot is silently dropped; the rest of the group still enters.
        if (i_valid[s] && ((e[BRM_LSB +: WIDTH_BRM] & i_BrKill) == '0)) begin
          e[VAL_BIT] = 1'b1;
          e = wake(e, i_wdest, i_wvalid);
          for (int p = 0; p < DEPTH; p++) begin
            if (p == k) ent_d[p] = e;
          end
          k++;
        end
      end
    end
    cnt_d = CW'(k);
  end

  // Entry storage and occupancy; reset overrides any same-cycle dispatch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_issue_queue_gen.sv
// Directed bench for issue_queue_gen with default parameters.
module tb_issue_queue_gen;

  localparam int W = 25;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [4*W-1:0] i_inst;
  logic [3:0]    i_valid;
  logic          i_en;
  logic [11:0]   i_wdest;
  logic [3:0]    i_wvalid;
  logic [2:0]    i_BrKill;
  logic [2*W-1:0] o_inst;
  logic [1:0]    o_valid;
  logic [3:0]    o_free;
  logic          o_ready;

  int n_vec = 0;
  int n_err = 0;

  issue_queue_gen dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_inst   (i_inst),
    .i_valid  (i_valid),
    .i_en     (i_en),
    .i_wdest  (i_wdest),
    .i_wvalid (i_wvalid),
    .i_BrKill (i_BrKill),
    .o_inst   (o_inst),
    .o_valid  (o_valid),
    .o_free   (o_free),
    .o_ready  (o_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entry with tag/prd/pr2 zero: {uop, brm, tag, prd, pr2, pr1, val, p2, p1}.
  function automatic logic [W-1:0] mk(input int uop, input logic [2:0] brm,
                                      input logic [2:0] pr1, input logic p1,
                                      input logic p2, input logic v);
    logic [W-1:0] e;
    logic [31:0]  u;
    u        = uop;
    e        = '0;
    e[18+:7] = u[6:0];
    e[15+:3] = brm;
    e[3+:3]  = pr1;
    e[2]     = v;
    e[1]     = p2;
    e[0]     = p1;
    return e;
  endfunction

  function automatic logic [6:0] uop_at(input int j);
    logic [W-1:0] e;
    e = o_inst[j*W +: W];
    return e[18+:7];
  endfunction

  task automatic clr_in();
    i_inst   = '0;
    i_valid  = '0;
    i_en     = 1'b0;
    i_wdest  = '0;
    i_wvalid = '0;
    i_BrKill = '0;
  endtask

  // Advance past one rising edge; outputs settle before inputs change.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic disp4(input int u0, input logic [2:0] brm, input logic [2:0] pr1,
                       input logic p1);
    for (int s = 0; s < 4; s++) i_inst[s*W +: W] = mk(u0 + s, brm, pr1, p1, 1'b1, 1'b0);
    i_valid = 4'b1111;
    i_en    = 1'b1;
  endtask

  initial begin
    clr_in();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_inst", 64'(o_inst), 64'd0);
    check("rst_free", 64'(o_free), 64'd8);
    check("rst_ready", 64'(o_ready), 64'd1);

    // Four ready entries issue two per cycle, oldest first.
    disp4(1, 3'b000, 3'd0, 1'b1);
    tick();
    clr_in();
    #1;
    check("rdy_v0", 64'(o_valid), 64'b11);
    check("rdy_u0a", 64'(uop_at(0)), 64'd1);
    check("rdy_u0b", 64'(uop_at(1)), 64'd2);
    check("rdy_full0", 64'(o_inst[0 +: W]), 64'(mk(1, 3'b000, 3'd0, 1'b1, 1'b1, 1'b1)));
    check("rdy_free0", 64'(o_free), 64'd4);
    tick();
    check("rdy_v1", 64'(o_valid), 64'b11);
    check("rdy_u1a", 64'(uop_at(0)), 64'd3);
    check("rdy_u1b", 64'(uop_at(1)), 64'd4);
    check("rdy_free1", 64'(o_free), 64'd6);
    tick();
    check("rdy_v2", 64'(o_valid), 64'b00);
    check("rdy_inst2", 64'(o_inst), 64'd0);
    check("rdy_free2", 64'(o_free), 64'd8);

    // Wakeup of pr1=6 makes all four ready after one edge.
    disp4(5, 3'b000, 3'b110, 1'b0);
    tick();
    clr_in();
    #1;
    check("wk_wait", 64'(o_valid), 64'b00);
    check("wk_free", 64'(o_free), 64'd4);
    i_wdest[2:0] = 3'b110;
    i_wvalid     = 4'b0001;
    tick();
    clr_in();
    #1;
    check("wk_v0", 64'(o_valid), 64'b11);
    check("wk_u0", 64'({uop_at(1), uop_at(0)}), 64'({7'd6, 7'd5}));
    tick();
    check("wk_u1", 64'({uop_at(1), uop_at(0)}), 64'({7'd8, 7'd7}));
    tick();
    check("wk_free_end", 64'(o_free), 64'd8);

    // Fill to 8, reject one more, then drain.
    disp4(9, 3'b000, 3'b101, 1'b0);
    tick();
    disp4(13, 3'b000, 3'b101, 1'b0);
    tick();
    clr_in();
    #1;
    check("full_free", 64'(o_free), 64'd0);
    check("full_ready", 64'(o_ready), 64'd0);
    i_inst[0 +: W] = mk(20, 3'b000, 3'd0, 1'b1, 1'b1, 1'b0);
    i_valid        = 4'b0001;
    i_en           = 1'b1;
    tick();
    clr_in();
    #1;
    check("rej_free", 64'(o_free), 64'd0);
    check("rej_valid", 64'(o_valid), 64'b00);
    i_wdest[5:3] = 3'b101;
    i_wvalid     = 4'b0010;
    tick();
    clr_in();
    #1;
    check("full_iss", 64'({uop_at(1), uop_at(0)}), 64'({7'd10, 7'd9}));
    check("full_iss_free", 64'(o_free), 64'd0);
    tick();
    check("full_free2", 64'(o_free), 64'd2);
    check("full_iss2", 64'({uop_at(1), uop_at(0)}), 64'({7'd12, 7'd11}));
    tick();
    tick();
    tick();
    check("full_drain", 64'(o_free), 64'd8);

    // Branch kill: 4 entries with brm=010, 2 with brm=001.
    disp4(21, 3'b010, 3'b100, 1'b0);
    tick();
    clr_in();
    i_inst[0 +: W] = mk(25, 3'b001, 3'b100, 1'b0, 1'b1, 1'b0);
    i_inst[W +: W] = mk(26, 3'b001, 3'b100, 1'b0, 1'b1, 1'b0);
    i_valid        = 4'b0011;
    i_en           = 1'b1;
    tick();
    clr_in();
    i_wdest[2:0] = 3'b100;
    i_wvalid     = 4'b0001;
    tick();
    clr_in();
    #1;
    check("bk_pre_free", 64'(o_free), 64'd2);
    check("bk_pre_u", 64'({uop_at(1), uop_at(0)}), 64'({7'd22, 7'd21}));
    i_BrKill = 3'b010;
    #1;
    check("bk_valid", 64'(o_valid), 64'b11);
    check("bk_u", 64'({uop_at(1), uop_at(0)}), 64'({7'd26, 7'd25}));
    tick();
    clr_in();
    #1;
    check("bk_free", 64'(o_free), 64'd8);
    check("bk_valid_after", 64'(o_valid), 64'b00);

    // Sparse dispatch slots pack without holes.
    for (int s = 0; s < 4; s++) i_inst[s*W +: W] = mk(30 + s, 3'b000, 3'd0, 1'b1, 1'b1, 1'b0);
    i_valid = 4'b1010;
    i_en    = 1'b1;
    tick();
    clr_in();
    #1;
    check("sp_valid", 64'(o_valid), 64'b11);
    check("sp_u", 64'({uop_at(1), uop_at(0)}), 64'({7'd33, 7'd31}));
    check("sp_free", 64'(o_free), 64'd6);
    tick();
    check("sp_free2", 64'(o_free), 64'd8);

    // Killed dispatch slot dropped; same-cycle wakeup applies to dispatch.
    i_inst[0 +: W] = mk(40, 3'b010, 3'd0, 1'b1, 1'b1, 1'b0);
    i_inst[W +: W] = mk(41, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0);
    i_valid        = 4'b0011;
    i_en           = 1'b1;
    i_BrKill       = 3'b010;
    i_wdest[11:9]  = 3'b111;
    i_wvalid       = 4'b1000;
    tick();
    clr_in();
    #1;
    check("dk_valid", 64'(o_valid), 64'b01);
    check("dk_u", 64'(uop_at(0)), 64'd41);
    check("dk_free", 64'(o_free), 64'd7);
    tick();
    check("dk_free2", 64'(o_free), 64'd8);

    // Dispatch disabled: nothing enters.
    disp4(50, 3'b000, 3'd0, 1'b1);
    i_en = 1'b0;
    tick();
    clr_in();
    #1;
    check("en_free", 64'(o_free), 64'd8);

    // Reset mid-operation with 5 pending entries and an active dispatch.
    disp4(60, 3'b000, 3'b001, 1'b0);
    tick();
    clr_in();
    i_inst[0 +: W] = mk(64, 3'b000, 3'b001, 1'b0, 1'b1, 1'b0);
    i_valid        = 4'b0001;
    i_en           = 1'b1;
    tick();
    clr_in();
    #1;
    check("mr_pend", 64'(o_free), 64'd3);
    disp4(70, 3'b000, 3'd0, 1'b1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    clr_in();
    #1;
    check("mr_free", 64'(o_free), 64'd8);
    check("mr_valid", 64'(o_valid), 64'b00);
    check("mr_ready", 64'(o_ready), 64'd1);
    tick();
    check("mr_valid2", 64'(o_valid), 64'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
